// File: rtl/alu_pkg.sv
// Shared definitions for the ALU request scheduler: opcode unit codes, FSM states, width defaults.
package alu_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 16;
    localparam int unsigned OUT_WIDTH_DEF  = 16;

    localparam logic [1:0] UNIT_ARITH = 2'b00;
    localparam logic [1:0] UNIT_LOGIC = 2'b01;
    localparam logic [1:0] UNIT_CMP   = 2'b10;
    localparam logic [1:0] UNIT_SHIFT = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    // One-hot unit enable vector ordered {shift, cmp, logic, arith}
    function automatic logic [3:0] unit_onehot(input logic [1:0] unit);
        logic [3:0] en;
        en = 4'b0000;
        case (unit)
            UNIT_ARITH: en = 4'b0001;
            UNIT_LOGIC: en = 4'b0010;
            UNIT_CMP:   en = 4'b0100;
            UNIT_SHIFT: en = 4'b1000;
            default:    en = 4'b0000;
        endcase
        return en;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: a lone requester wins, a tie goes to the one not granted last.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant,
    output logic       any
);

    assign any = |req;

    always_comb begin
        grant = req[1];
        if (req == 2'b11) begin
            grant = ~last_grant;
        end
    end

endmodule

// File: rtl/alu_req_scheduler.sv
// Shares one registered ALU between two requesters: arbitrate, issue, capture the result, respond.
module alu_req_scheduler
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned OUT_WIDTH  = OUT_WIDTH_DEF
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [1:0]            REQ_VALID,
    output logic [1:0]            REQ_READY,
    input  logic [DATA_WIDTH-1:0] REQ0_A,
    input  logic [DATA_WIDTH-1:0] REQ0_B,
    input  logic [DATA_WIDTH-1:0] REQ1_A,
    input  logic [DATA_WIDTH-1:0] REQ1_B,
    input  logic [3:0]            REQ0_OP,
    input  logic [3:0]            REQ1_OP,
    output logic [DATA_WIDTH-1:0] ALU_A,
    output logic [DATA_WIDTH-1:0] ALU_B,
    output logic [1:0]            ALU_FUNC,
    output logic                  Arith_Enable,
    output logic                  Logic_Enable,
    output logic                  CMP_Enable,
    output logic                  SHIFT_Enable,
    input  logic [OUT_WIDTH-1:0]  ALU_OUT,
    input  logic                  OUT_FLAG,
    output logic                  RSP_VALID,
    input  logic                  RSP_READY,
    output logic                  RSP_ID,
    output logic [OUT_WIDTH-1:0]  RSP_DATA,
    output logic                  RSP_ERR,
    output logic                  BUSY
);

    state_t                  state;
    logic                    last_grant;
    logic                    held_id;
    logic [3:0]              unit_en;
    logic                    grant;
    logic                    any;
    logic [DATA_WIDTH-1:0]   sel_a;
    logic [DATA_WIDTH-1:0]   sel_b;
    logic [3:0]              sel_op;

    rr_arbiter2 u_arb (
        .req        (REQ_VALID),
        .last_grant (last_grant),
        .grant      (grant),
        .any        (any)
    );

    assign sel_a  = grant ? REQ1_A  : REQ0_A;
    assign sel_b  = grant ? REQ1_B  : REQ0_B;
    assign sel_op = grant ? REQ1_OP : REQ0_OP;

    // Ready is combinational from the grant; held low while reset is asserted so nothing is offered then
    assign REQ_READY = (RST && (state == IDLE) && any) ? (grant ? 2'b10 : 2'b01) : 2'b00;

    assign Arith_Enable = unit_en[0];
    assign Logic_Enable = unit_en[1];
    assign CMP_Enable   = unit_en[2];
    assign SHIFT_Enable = unit_en[3];

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            held_id    <= 1'b0;
            unit_en    <= 4'b0000;
            ALU_A      <= '0;
            ALU_B      <= '0;
            ALU_FUNC   <= 2'b00;
            RSP_VALID  <= 1'b0;
            RSP_ID     <= 1'b0;
            RSP_DATA   <= '0;
            RSP_ERR    <= 1'b0;
            BUSY       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any) begin
                        ALU_A      <= sel_a;
                        ALU_B      <= sel_b;
                        ALU_FUNC   <= sel_op[1:0];
                        unit_en    <= unit_onehot(sel_op[3:2]);
                        held_id    <= grant;
                        last_grant <= grant;
                        BUSY       <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    // ALU samples operands on this edge; enables drop so it never fires twice
                    unit_en <= 4'b0000;
                    state   <= CAPTURE;
                end
                CAPTURE: begin
                    RSP_DATA  <= ALU_OUT;
                    RSP_ERR   <= ~OUT_FLAG;
                    RSP_ID    <= held_id;
                    RSP_VALID <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (RSP_READY) begin
                        RSP_VALID <= 1'b0;
                        BUSY      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Randomized self-checking bench for alu_req_scheduler with a behavioural ALU and transaction-level model.
module tb_alu_req_scheduler;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [1:0]  REQ_VALID = 2'b00;
    logic [1:0]  REQ_READY;
    logic [15:0] REQ0_A = '0, REQ0_B = '0, REQ1_A = '0, REQ1_B = '0;
    logic [3:0]  REQ0_OP = '0, REQ1_OP = '0;
    logic [15:0] ALU_A, ALU_B;
    logic [1:0]  ALU_FUNC;
    logic        Arith_Enable, Logic_Enable, CMP_Enable, SHIFT_Enable;
    logic [15:0] ALU_OUT = '0;
    logic        OUT_FLAG = 1'b0;
    logic        RSP_VALID;
    logic        RSP_READY = 1'b0;
    logic        RSP_ID;
    logic [15:0] RSP_DATA;
    logic        RSP_ERR;
    logic        BUSY;

    int n_chk  = 0;
    int n_pass = 0;
    bit model_last = 1'b1;
    bit alu_err = 1'b0;

    always #5 CLK = ~CLK;

    alu_req_scheduler dut (
        .CLK(CLK), .RST(RST),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ0_A(REQ0_A), .REQ0_B(REQ0_B), .REQ1_A(REQ1_A), .REQ1_B(REQ1_B),
        .REQ0_OP(REQ0_OP), .REQ1_OP(REQ1_OP),
        .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUNC(ALU_FUNC),
        .Arith_Enable(Arith_Enable), .Logic_Enable(Logic_Enable),
        .CMP_Enable(CMP_Enable), .SHIFT_Enable(SHIFT_Enable),
        .ALU_OUT(ALU_OUT), .OUT_FLAG(OUT_FLAG),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_ID(RSP_ID),
        .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR), .BUSY(BUSY)
    );

    function automatic logic [15:0] calc(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op);
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a + 16'd1;
            4'd3:  return a - 16'd1;
            4'd4:  return a & b;
            4'd5:  return a | b;
            4'd6:  return a ^ b;
            4'd7:  return ~(a & b);
            4'd8:  return {15'd0, a == b};
            4'd9:  return {15'd0, a > b};
            4'd10: return {15'd0, a < b};
            4'd11: return {15'd0, a != b};
            4'd12: return a << 1;
            4'd13: return a >> 1;
            4'd14: return a << b[3:0];
            default: return a >> b[3:0];
        endcase
    endfunction

    function automatic logic [3:0] ens();
        return {SHIFT_Enable, CMP_Enable, Logic_Enable, Arith_Enable};
    endfunction

    // Behavioural ALU: one-cycle registered result, flag reports a valid result unless an error is injected
    always @(posedge CLK) begin
        logic [1:0] unit;
        unit = SHIFT_Enable ? 2'd3 : CMP_Enable ? 2'd2 : Logic_Enable ? 2'd1 : 2'd0;
        if (Arith_Enable | Logic_Enable | CMP_Enable | SHIFT_Enable) begin
            ALU_OUT  <= calc(ALU_A, ALU_B, {unit, ALU_FUNC});
            OUT_FLAG <= !alu_err;
        end else begin
            OUT_FLAG <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ready"}, 64'(REQ_READY), 64'd0);
        chk({tag, "_en"}, 64'(ens()), 64'd0);
        chk({tag, "_alu"}, 64'({ALU_A, ALU_B, ALU_FUNC}), 64'd0);
        chk({tag, "_rsp"}, 64'({RSP_VALID, RSP_ID, RSP_ERR, RSP_DATA}), 64'd0);
        chk({tag, "_busy"}, 64'(BUSY), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        model_last = 1'b1;
    endtask

    // Idle gap; also shows a valid pulse withdrawn before any edge leaves the scheduler untouched
    task automatic idle(input int n);
        REQ_VALID = 2'b11;
        #1 chk("idle_offer", 64'(REQ_READY != 2'b00), 64'd1);
        #1 REQ_VALID = 2'b00;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            chk("idle_ready", 64'(REQ_READY), 64'd0);
            chk("idle_busy", 64'(BUSY), 64'd0);
            chk("idle_rsp", 64'(RSP_VALID), 64'd0);
        end
    endtask

    task automatic do_txn(input logic [1:0] vld, input logic [15:0] a0, input logic [15:0] b0,
                          input logic [15:0] a1, input logic [15:0] b1, input logic [3:0] op0,
                          input logic [3:0] op1, input int stall, input bit err);
        bit g;
        logic [15:0] ea, eb, ed;
        logic [3:0] eop;
        if (vld == 2'b11) g = ~model_last;
        else g = vld[1];
        ea  = g ? a1 : a0;
        eb  = g ? b1 : b0;
        eop = g ? op1 : op0;
        ed  = calc(ea, eb, eop);
        REQ_VALID = vld;
        REQ0_A = a0; REQ0_B = b0; REQ1_A = a1; REQ1_B = b1;
        REQ0_OP = op0; REQ1_OP = op1;
        RSP_READY = (stall == 0);
        alu_err = err;
        #1;
        chk("req_ready", 64'(REQ_READY), g ? 64'd2 : 64'd1);
        chk("busy_idle", 64'(BUSY), 64'd0);
        @(negedge CLK);
        model_last = g;
        REQ_VALID = 2'($urandom);
        REQ0_A = 16'($urandom); REQ1_A = 16'($urandom);
        REQ0_OP = 4'($urandom); REQ1_OP = 4'($urandom);
        chk("en_issue", 64'(ens()), 64'(4'b0001 << eop[3:2]));
        chk("func_issue", 64'(ALU_FUNC), 64'(eop[1:0]));
        chk("alu_ab", 64'({ALU_A, ALU_B}), 64'({ea, eb}));
        chk("ready_issue", 64'(REQ_READY), 64'd0);
        chk("busy_issue", 64'(BUSY), 64'd1);
        @(negedge CLK);
        chk("en_capture", 64'(ens()), 64'd0);
        chk("rsp_early", 64'(RSP_VALID), 64'd0);
        chk("alu_hold", 64'({ALU_A, ALU_B, ALU_FUNC}), 64'({ea, eb, eop[1:0]}));
        for (int i = 0; i <= stall; i++) begin
            @(negedge CLK);
            chk("rsp_valid", 64'(RSP_VALID), 64'd1);
            chk("rsp_data", 64'(RSP_DATA), 64'(ed));
            chk("rsp_id_err", 64'({RSP_ID, RSP_ERR}), 64'({g, err}));
            chk("ready_resp", 64'(REQ_READY), 64'd0);
            chk("busy_resp", 64'(BUSY), 64'd1);
            chk("en_resp", 64'(ens()), 64'd0);
            REQ_VALID = 2'($urandom);
            if (i == stall) RSP_READY = 1'b1;
        end
        @(negedge CLK);
        chk("rsp_done", 64'({RSP_VALID, BUSY}), 64'd0);
        REQ_VALID = 2'b00;
        RSP_READY = 1'b0;
        alu_err = 1'b0;
    endtask

    initial begin
        REQ_VALID = 2'b11;
        @(negedge CLK);
        chk_zero("reset");
        RST = 1'b1;
        REQ_VALID = 2'b00;

        do_txn(2'b01, 16'h00F0, 16'h0FF0, 16'h0, 16'h0, 4'b0100, 4'b0000, 0, 1'b0);

        do_reset();
        for (int i = 0; i < 4; i++)
            do_txn(2'b11, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                   4'b0101, 4'b0110, 0, 1'b0);

        do_txn(2'b01, 16'h1234, 16'h0F0F, 16'h0, 16'h0, 4'b0110, 4'b0000, 10, 1'b0);
        do_txn(2'b10, 16'h0, 16'h0, 16'hA5A5, 16'h0003, 4'b0000, 4'b0000, 0, 1'b1);

        for (int op = 0; op < 16; op++)
            do_txn(2'b10, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                   4'($urandom), 4'(op), 0, 1'b0);

        REQ_VALID = 2'b01; REQ0_A = 16'h7777; REQ0_B = 16'h1111; REQ0_OP = 4'b0000;
        @(negedge CLK);
        @(negedge CLK);
        REQ_VALID = 2'b11;
        #2 RST = 1'b0;
        #1 chk_zero("rst_mid");
        @(negedge CLK);
        RST = 1'b1;
        model_last = 1'b1;
        REQ_VALID = 2'b00;
        do_txn(2'b11, 16'h0042, 16'h0001, 16'h9999, 16'h9999, 4'b0000, 4'b0101, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [1:0] v;
            v = 2'($urandom_range(1, 3));
            do_txn(v, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                   4'($urandom), 4'($urandom),
                   ($urandom_range(0, 7) == 0) ? 10 : int'($urandom_range(0, 2)),
                   ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
